// File: rtl/adaptive_binarizer_if.sv
// Pixel stream bundle for adaptive_binarizer.
// master: the upstream grayscale stage (drives pixels, reads results).
// slave : the binarizer itself.
// DATA_W must match the DATA_W of the attached adaptive_binarizer.
interface adaptive_binarizer_if #(
   parameter int DATA_W = 12
);
   logic              iFVAL;
   logic              iDVAL;
   logic [DATA_W-1:0] iDATA;
   logic              iMODE;
   logic [DATA_W-1:0] iTHR;
   logic              oDVAL;
   logic [DATA_W-1:0] oDATA;
   logic [DATA_W-1:0] oTHR;
   logic              oBUSY;

   modport master (
      output iFVAL, iDVAL, iDATA, iMODE, iTHR,
      input  oDVAL, oDATA, oTHR, oBUSY
   );

   modport slave (
      input  iFVAL, iDVAL, iDATA, iMODE, iTHR,
      output oDVAL, oDATA, oTHR, oBUSY
   );
endinterface

// File: rtl/adaptive_binarizer.sv
// Pixel binarizer with fixed or frame-adaptive threshold.
// In adaptive mode a frame uses the truncated mean luminance of the previous
// frame, produced by a bit-serial restoring divider (one quotient bit/cycle).
// Optional build macro BINARIZER_HYST_EN adds per-pixel hysteresis of +/-HYST
// around the threshold; without it the compare is a plain strict "greater than".
module adaptive_binarizer #(
   parameter int DATA_W   = 12,
   parameter int INIT_THR = 947,
   parameter int CNT_W    = 24
`ifdef BINARIZER_HYST_EN
   ,parameter int HYST    = 16
`endif
) (
   input logic                 iCLK,
   input logic                 iRST,
   adaptive_binarizer_if.slave bus
);
   localparam int SUM_W = DATA_W + CNT_W;
   localparam int BC_W  = $clog2(SUM_W);
   localparam logic [DATA_W-1:0] THR_RST  = DATA_W'(INIT_THR);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(SUM_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

   state_t state_q, state_d;

   logic              fval_q, fval_d;
   logic              dval_q, dval_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] thr_q, thr_d;
   logic [DATA_W-1:0] nthr_q, nthr_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SUM_W-1:0]  quot_q, quot_d;
   logic [CNT_W-1:0]  dvs_q, dvs_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [BC_W-1:0]   bit_q, bit_d;
`ifdef BINARIZER_HYST_EN
   logic              s_q, s_d, s_cur;
`endif

   logic              frame_rise, frame_fall;
   logic              white;
   logic              busy, div_start, div_step, div_commit;
   logic [CNT_W:0]    rem_sh;
   logic              rem_ge;

`ifdef BINARIZER_HYST_EN
   // Upper band edge, clamped at full scale.
   function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a);
      logic [DATA_W:0] s;
      s = {1'b0, a} + (DATA_W+1)'(HYST);
      sat_add = s[DATA_W] ? '1 : s[DATA_W-1:0];
   endfunction

   // Lower band edge, clamped at zero.
   function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a);
      logic [DATA_W:0] d;
      d = {1'b0, a} - (DATA_W+1)'(HYST);
      sat_sub = d[DATA_W] ? '0 : d[DATA_W-1:0];
   endfunction
`endif

   assign frame_rise = bus.iFVAL & ~fval_q;
   assign frame_fall = ~bus.iFVAL & fval_q;

   // Threshold selection at frame start and the one-cycle pixel compare;
   // a pixel on the rising-edge cycle already sees the newly loaded threshold.
   always_comb begin
      fval_d = bus.iFVAL;
      dval_d = bus.iDVAL;
      thr_d  = thr_q;
      if (frame_rise) thr_d = bus.iMODE ? nthr_q : bus.iTHR;
      white = 1'b0;
`ifdef BINARIZER_HYST_EN
      s_cur = frame_rise ? 1'b0 : s_q;
      s_d   = s_cur;
      if (bus.iDVAL) begin
         if (!s_cur) white = bus.iDATA > sat_add(thr_d);
         else        white = !(bus.iDATA < sat_sub(thr_d));
         s_d = white;
      end
`else
      white = bus.iDVAL && (bus.iDATA > thr_d);
`endif
      data_d = {DATA_W{white}};
   end

   // Per-frame sum/count of valid pixels; saturate at the count limit, clear at frame end.
   always_comb begin
      sum_d = sum_q;
      cnt_d = cnt_q;
      if (frame_fall) begin
         sum_d = '0;
         cnt_d = '0;
      end else if (bus.iFVAL && bus.iDVAL && (cnt_q != CNT_MAX)) begin
         sum_d = sum_q + SUM_W'(bus.iDATA);
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Divider state register.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Divider next state: a frame end while not idle is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (div_start) state_d = S_DIV;
         S_DIV:   if (bit_q == LAST_BIT) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Divider control outputs.
   always_comb begin
      busy       = (state_q == S_DIV);
      div_step   = (state_q == S_DIV);
      div_commit = (state_q == S_DONE);
      div_start  = (state_q == S_IDLE) && frame_fall && (cnt_q != '0);
   end

   // Restoring division: dividend shifts out of quot MSB-first while quotient bits shift in.
   always_comb begin
      quot_d = quot_q;
      dvs_d  = dvs_q;
      rem_d  = rem_q;
      bit_d  = bit_q;
      nthr_d = nthr_q;
      rem_sh = {rem_q, quot_q[SUM_W-1]};
      rem_ge = rem_sh >= {1'b0, dvs_q};
      if (div_start) begin
         quot_d = sum_q;
         dvs_d  = cnt_q;
         rem_d  = '0;
         bit_d  = '0;
      end else if (div_step) begin
         rem_d  = rem_ge ? CNT_W'(rem_sh - {1'b0, dvs_q}) : rem_sh[CNT_W-1:0];
         quot_d = {quot_q[SUM_W-2:0], rem_ge};
         bit_d  = bit_q + BC_W'(1);
      end
      // The mean never exceeds the largest pixel, so the low DATA_W bits hold it exactly.
      if (div_commit) nthr_d = quot_q[DATA_W-1:0];
   end

   // Datapath and control registers.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         fval_q <= 1'b0;
         dval_q <= 1'b0;
         data_q <= '0;
         thr_q  <= THR_RST;
         nthr_q <= THR_RST;
         sum_q  <= '0;
         cnt_q  <= '0;
         quot_q <= '0;
         dvs_q  <= '0;
         rem_q  <= '0;
         bit_q  <= '0;
`ifdef BINARIZER_HYST_EN
         s_q    <= 1'b0;
`endif
      end else begin
         fval_q <= fval_d;
         dval_q <= dval_d;
         data_q <= data_d;
         thr_q  <= thr_d;
         nthr_q <= nthr_d;
         sum_q  <= sum_d;
         cnt_q  <= cnt_d;
         quot_q <= quot_d;
         dvs_q  <= dvs_d;
         rem_q  <= rem_d;
         bit_q  <= bit_d;
`ifdef BINARIZER_HYST_EN
         s_q    <= s_d;
`endif
      end
   end

   assign bus.oDVAL = dval_q;
   assign bus.oDATA = data_q;
   assign bus.oTHR  = thr_q;
   assign bus.oBUSY = busy;
endmodule

// File: tb/tb_adaptive_binarizer.sv
// Directed bench for adaptive_binarizer with a frame-level reference model.
module tb_adaptive_binarizer;
   localparam int DW    = 12;
   localparam int WHITE = 4095;
   localparam int IT    = 947;
   localparam int SUMW  = 36;
   localparam int CMAX  = (1 << 24) - 1;
   localparam int HY    = 16;

   logic clk = 1'b0;
   logic rst_n;

   adaptive_binarizer_if #(.DATA_W(DW)) bus ();

   adaptive_binarizer #(.DATA_W(DW), .INIT_THR(IT), .CNT_W(24)) dut (
      .iCLK(clk),
      .iRST(rst_n),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   int     m_thr, m_next, m_prev, m_cnt, m_busy_left, m_done_pend, m_pend, m_s;
   longint m_sum;
   int     e_dval, e_data;

   function automatic void model_reset();
      m_thr = IT; m_next = IT; m_prev = 0; m_cnt = 0; m_sum = 0;
      m_busy_left = 0; m_done_pend = 0; m_pend = 0; m_s = 0;
      e_dval = 0; e_data = 0;
   endfunction

   function automatic void model_step(input int f, input int d, input int x, input int mode, input int thr);
      int idle_pre, white;
      idle_pre = (m_busy_left == 0 && m_done_pend == 0);
      if (f == 1 && m_prev == 0) begin
         m_thr = (mode == 1) ? m_next : thr;
         m_s = 0;
      end
`ifdef BINARIZER_HYST_EN
      white = 0;
      if (d == 1) begin
         int hi, lo;
         hi = (m_thr + HY > WHITE) ? WHITE : m_thr + HY;
         lo = (m_thr - HY < 0) ? 0 : m_thr - HY;
         if (m_s == 0) white = (x > hi) ? 1 : 0;
         else          white = (x < lo) ? 0 : 1;
         m_s = white;
      end
`else
      white = (d == 1 && x > m_thr) ? 1 : 0;
`endif
      e_dval = d;
      e_data = white ? WHITE : 0;
      if (m_busy_left > 0) begin
         m_busy_left--;
         if (m_busy_left == 0) m_done_pend = 1;
      end else if (m_done_pend == 1) begin
         m_next = m_pend;
         m_done_pend = 0;
      end
      if (f == 0 && m_prev == 1) begin
         if (idle_pre == 1 && m_cnt > 0) begin
            m_pend = int'(m_sum / m_cnt);
            m_busy_left = SUMW;
         end
         m_sum = 0;
         m_cnt = 0;
      end else if (f == 1 && d == 1 && m_cnt < CMAX) begin
         m_sum += x;
         m_cnt++;
      end
      m_prev = f;
   endfunction

   // Cycle-by-cycle compare against the model, just after each active edge.
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) model_reset();
         else model_step(int'(bus.iFVAL), int'(bus.iDVAL), int'(bus.iDATA), int'(bus.iMODE), int'(bus.iTHR));
         chk("cyc_oDVAL", int'(bus.oDVAL), e_dval);
         chk("cyc_oDATA", int'(bus.oDATA), e_data);
         chk("cyc_oTHR",  int'(bus.oTHR),  m_thr);
         chk("cyc_oBUSY", int'(bus.oBUSY), (m_busy_left > 0) ? 1 : 0);
      end
   end

   task automatic drive(input bit f, input bit d, input int x);
      @(negedge clk);
      bus.iFVAL = f;
      bus.iDVAL = d;
      bus.iDATA = DW'(x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
   endtask

   task automatic pix_expect(input string name, input int x, input int exp);
      drive(1'b1, 1'b1, x);
      @(posedge clk);
      #1;
      chk(name, int'(bus.oDATA), exp);
   endtask

   task automatic count_busy(input string name, input int window, input int exp);
      int n;
      n = 0;
      for (int i = 0; i < window; i++) begin
         @(posedge clk);
         #1;
         if (bus.oBUSY) n++;
      end
      chk(name, n, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      bus.iFVAL = 1'b0; bus.iDVAL = 1'b0; bus.iDATA = '0; bus.iMODE = 1'b0; bus.iTHR = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_oTHR",  int'(bus.oTHR),  IT);
      chk("rst_oDATA", int'(bus.oDATA), 0);
      chk("rst_oDVAL", int'(bus.oDVAL), 0);
      chk("rst_oBUSY", int'(bus.oBUSY), 0);
      rst_n = 1'b1;
      idle(2);

      // Fixed threshold 947
      bus.iMODE = 1'b0; bus.iTHR = DW'(947);
      drive(1'b1, 1'b0, 0);
      pix_expect("fix_948", 948, WHITE);
      pix_expect("fix_947", 947, 0);
      pix_expect("fix_4095", 4095, WHITE);
      pix_expect("fix_0", 0, 0);
      chk("fix_oTHR", int'(bus.oTHR), 947);
      drive(1'b0, 1'b0, 0);
      idle(45);

      // Adaptive frame 1: mean of 100..400 is 250
      bus.iMODE = 1'b1; bus.iTHR = '0;
      drive(1'b1, 1'b0, 0);
      drive(1'b1, 1'b1, 100);
      drive(1'b1, 1'b1, 200);
      drive(1'b1, 1'b1, 300);
      drive(1'b1, 1'b1, 400);
      drive(1'b0, 1'b0, 0);
      count_busy("ad_busy_cycles", 100, 36);

      // Adaptive frame 2 uses 250; mid-frame config changes are ignored
      drive(1'b1, 1'b0, 0);
      pix_expect("ad_251", 251, WHITE);
      chk("ad_oTHR", int'(bus.oTHR), 250);
      pix_expect("ad_250", 250, 0);
      bus.iMODE = 1'b0; bus.iTHR = DW'(5);
      pix_expect("ad_mid_260", 260, WHITE);
      chk("ad_mid_oTHR", int'(bus.oTHR), 250);
      drive(1'b0, 1'b0, 0);
      idle(45);

      // Empty frame: threshold 761/3 = 253 carries over, divider idle
      bus.iMODE = 1'b1;
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 0);
      chk("empty_oTHR", int'(bus.oTHR), 253);
      drive(1'b0, 1'b0, 0);
      count_busy("empty_busy_cycles", 40, 0);
      drive(1'b1, 1'b0, 0);
      @(posedge clk); #1;
      chk("after_empty_oTHR", int'(bus.oTHR), 253);
      drive(1'b0, 1'b0, 0);
      idle(3);

      // Early frame start: restart at 947, frame A mean 500
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      bus.iMODE = 1'b1;
      drive(1'b1, 1'b0, 0);
      drive(1'b1, 1'b1, 400);
      drive(1'b1, 1'b1, 600);
      @(posedge clk); #1;
      chk("early_A_oTHR", int'(bus.oTHR), 947);
      drive(1'b0, 1'b0, 0);
      idle(9);
      drive(1'b1, 1'b0, 0);
      pix_expect("early_B_948", 948, WHITE);
      chk("early_B_oTHR", int'(bus.oTHR), 947);
      drive(1'b1, 1'b1, 2000);
      drive(1'b0, 1'b0, 0);
      idle(40);
      drive(1'b1, 1'b0, 0);
      pix_expect("early_C_501", 501, WHITE);
      chk("early_C_oTHR", int'(bus.oTHR), 500);
      pix_expect("early_C_500", 500, 0);

      // Reset in the middle of a division
      drive(1'b0, 1'b0, 0);
      idle(5);
      chk("middiv_busy_before", int'(bus.oBUSY), 1);
      rst_n = 1'b0;
      #1;
      chk("middiv_rst_oBUSY", int'(bus.oBUSY), 0);
      chk("middiv_rst_oTHR",  int'(bus.oTHR),  947);
      chk("middiv_rst_oDATA", int'(bus.oDATA), 0);
      chk("middiv_rst_oDVAL", int'(bus.oDVAL), 0);
      @(negedge clk); rst_n = 1'b1;
      drive(1'b1, 1'b0, 0);
      pix_expect("postrst_948", 948, WHITE);
      chk("postrst_oTHR", int'(bus.oTHR), 947);
      drive(1'b0, 1'b0, 0);
      idle(45);

`ifdef BINARIZER_HYST_EN
      // Hysteresis around 500: band 484..516
      bus.iMODE = 1'b0; bus.iTHR = DW'(500);
      drive(1'b1, 1'b0, 0);
      pix_expect("hyst_510", 510, 0);
      pix_expect("hyst_517", 517, WHITE);
      pix_expect("hyst_490", 490, WHITE);
      pix_expect("hyst_483", 483, 0);
      drive(1'b0, 1'b0, 0);
      idle(45);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
